apb_req_master: RTL and testbench
=================================

Name: apb_req_master

Overview:
Upstream stage of the APB node. Converts a simple valid/ready request/response channel (from the core-side interconnect) into single APB3 transfers on one APB master port. That port feeds the node's slave-side inputs, and the node then decodes the address onto its NB_MASTER peripheral ports. The block adds an alignment check and an ACCESS-phase timeout so that a hung peripheral cannot stall the requester.

Parameters:
APB_ADDR_WIDTH, 32, width of request address and paddr_o
APB_DATA_WIDTH, 32, width of wdata/rdata (8, 16, 32 or 64)
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before abort; 0 disables the timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when high with req_valid_i
req_addr_i  in  APB_ADDR_WIDTH  byte address
req_we_i  in  1  1=write, 0=read
req_wdata_i  in  APB_DATA_WIDTH  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  APB_DATA_WIDTH  read data (0 for writes and errors)
rsp_err_o  out  1  slave error, misalignment or timeout
paddr_o  out  APB_ADDR_WIDTH  APB address
pwdata_o  out  APB_DATA_WIDTH  APB write data
pwrite_o  out  1  APB direction
psel_o  out  1  APB select
penable_o  out  1  APB enable
prdata_i  in  APB_DATA_WIDTH  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error
timeout_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - state=IDLE.
  - All outputs 0: psel_o, penable_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, paddr_o, pwdata_o, pwrite_o and timeout_o are 0.
  - req_ready_o becomes 1 once in IDLE.
  - Reset mid-transfer drops the transaction; no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- Output timing: APB outputs and rsp_* are registered or decoded from state only. There is no combinational path from any input to any output.
- req_ready_o = (state==IDLE).
- IDLE:
  - On req_valid_i & req_ready_o, capture addr, we and wdata.
  - Misaligned address (addr[log2(APB_DATA_WIDTH/8)-1:0] != 0): go to RESP with err=1 and rdata=0. No APB cycle is issued.
  - Otherwise go to SETUP.
- SETUP: psel_o=1, penable_o=0. paddr_o, pwdata_o and pwrite_o carry the captured values. Lasts exactly 1 cycle, then ACCESS. pready_i is ignored in SETUP.
- ACCESS: psel_o=1, penable_o=1. The cycle counter starts at 1 on the first ACCESS cycle.
  - If pready_i: capture rdata (prdata_i for reads, 0 for writes) and err=pslverr_i, then go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES: err=1, rdata=0, pulse timeout_o on the next cycle, then go to RESP.
  - pready_i on the final allowed cycle wins over the timeout.
  - pslverr_i is sampled only with pready_i in ACCESS.
- Leaving ACCESS: psel_o and penable_o are 0 on the cycle after ACCESS ends (no back-to-back transfers).
- Held values: paddr_o, pwdata_o and pwrite_o hold their last values until the next capture. They are not cleared.
- RESP: rsp_valid_o=1, with rsp_rdata_o and rsp_err_o stable until rsp_ready_i. On the handshake, go to IDLE.
- Minimum latency: accept at T, SETUP at T+1, ACCESS at T+2, rsp_valid at T+3 (zero-wait slave).
- Throughput: at most one transaction per 4 cycles.
- Counter width: clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

Test Plan:
- Zero-wait read: req addr=0x1A10_0004, we=0; pready=1 in the first ACCESS cycle with prdata=0xDEADBEEF -> psel at T+1, penable at T+2, rsp_valid at T+3 with rdata=0xDEADBEEF, err=0.
- Wait-state write with error: addr=0x1A10_0010, wdata=0x12345678; pready low for 3 ACCESS cycles, then pready=1 with pslverr=1 -> pwdata stable for all 4 ACCESS cycles, rsp_err=1, rsp_rdata=0.
- Misaligned request: addr=0x1A10_0002 -> psel never asserts; rsp_valid at T+1 with err=1.
- Timeout: TIMEOUT_CYCLES=16, pready held 0 -> exactly 16 penable cycles, timeout_o pulses once, rsp_err=1. Repeat with pready=1 on ACCESS cycle 16 -> normal completion, no timeout.
- Response backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata/err stable, req_ready=0 throughout. After the handshake, req_ready=1 the next cycle.
- Reset mid-ACCESS: assert rst_i during a waited read -> on the next edge psel=penable=0 and rsp_valid=0, with no response; a following request completes normally.

Source files
------------

// File: rtl/apb_req_master.sv
`default_nettype none
// ============================================================================
// apb_req_master : valid/ready request channel to single APB3 transfers, with
//                  alignment check and ACCESS-phase timeout.  Revision 1.0
// ============================================================================
module apb_req_master #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_we_i,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i,
    output logic                      timeout_o
);

    localparam int ALIGN_BITS = $clog2(APB_DATA_WIDTH / 8);
    localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [APB_ADDR_WIDTH-1:0] ALIGN_MASK =
        APB_ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             misaligned;
    logic             timeout_hit;

    assign misaligned  = |(req_addr_i & ALIGN_MASK);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LIMIT);

    // Handshake and APB strobes are pure state decodes, so no input reaches an output.
    assign req_ready_o = (state == IDLE);
    assign psel_o      = (state == SETUP) || (state == ACCESS);
    assign penable_o   = (state == ACCESS);
    assign rsp_valid_o = (state == RESP);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pwrite_o    <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        paddr_o  <= req_addr_i;
                        pwdata_o <= req_wdata_i;
                        pwrite_o <= req_we_i;
                        if (misaligned) begin
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                            state       <= RESP;
                        end else begin
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    cnt   <= CNT_W'(1);
                    state <= ACCESS;
                end
                ACCESS: begin
                    // pready on the last allowed cycle takes priority over the abort.
                    if (pready_i) begin
                        rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                        rsp_err_o   <= pslverr_i;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b1;
                        timeout_o   <= 1'b1;
                        state       <= RESP;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_req_master.sv
`default_nettype none
// ============================================================================
// tb_apb_req_master : directed + randomized bench with an APB slave responder
//                     and a transaction-level expectation model. Revision 1.0
// ============================================================================
module tb_apb_req_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_we;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic          timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apb_req_master #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .req_we_i   (req_we),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .paddr_o    (paddr),
        .pwdata_o   (pwdata),
        .pwrite_o   (pwrite),
        .psel_o     (psel),
        .penable_o  (penable),
        .prdata_i   (prdata),
        .pready_i   (pready),
        .pslverr_i  (pslverr),
        .timeout_o  (timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One request; the bench plays the APB slave, holding pready low for
    // 'waits' ACCESS cycles, and expectations come from the transfer rules.
    task automatic run_txn(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wdata,
                           input int waits, input logic slverr, input logic [DW-1:0] rdat,
                           input int hold);
        bit            mis       = (addr[1:0] != 2'b00);
        bit            tmo       = !mis && (TO != 0) && (waits >= TO);
        int            exp_pen   = mis ? 0 : (tmo ? TO : waits + 1);
        int            exp_rsp_k = mis ? 1 : 2 + exp_pen;
        logic [DW-1:0] exp_rdata = (mis || tmo || we) ? '0 : rdat;
        logic          exp_err   = mis || tmo || slverr;
        int            pen_cnt   = 0;
        int            sel_cnt   = 0;
        int            tmo_cnt   = 0;
        int            rsp_k     = -1;
        int            first_pen = -1;
        bit            stable_ok = 1'b1;

        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_we    = we;
        req_wdata = wdata;
        prdata    = rdat;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_we    = 1'($urandom);
            end
            if (psel) begin
                sel_cnt++;
                if (paddr !== addr || pwrite !== we || pwdata !== wdata) stable_ok = 1'b0;
            end
            if (penable) begin
                pen_cnt++;
                if (first_pen < 0) first_pen = k;
            end
            if (timeout) tmo_cnt++;
            if (rsp_valid) begin
                rsp_k = k;
                break;
            end
            if (penable) begin
                pready  = (pen_cnt > waits);
                pslverr = pready ? slverr : 1'($urandom);
            end else begin
                pready  = 1'($urandom);
                pslverr = 1'($urandom);
            end
        end
        pready  = 1'b0;
        pslverr = 1'b0;

        chk("rsp_latency", rsp_k, exp_rsp_k);
        chk("penable_cycles", pen_cnt, exp_pen);
        chk("psel_cycles", sel_cnt, mis ? 0 : exp_pen + 1);
        if (!mis) chk("first_penable", first_pen, 2);
        chk("apb_stable", stable_ok, 1);
        chk("timeout_pulses", tmo_cnt, tmo);
        if (rsp_k < 0) return;
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", rsp_err, exp_err);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, exp_rdata);
            chk("hold_err", rsp_err, exp_err);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_timeout", timeout, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_req_ready", req_ready, 1);
        chk("post_hs_rsp_valid", rsp_valid, 0);
        chk("post_hs_psel", psel, 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;

        // Zero-wait read, wait-state write with slave error, misaligned access.
        run_txn(32'h1A10_0004, 1'b0, 32'h0000_0000, 0, 1'b0, 32'hDEAD_BEEF, 0);
        run_txn(32'h1A10_0010, 1'b1, 32'h1234_5678, 3, 1'b1, 32'hCAFE_F00D, 0);
        run_txn(32'h1A10_0002, 1'b0, 32'h0000_0000, 0, 1'b0, 32'h5555_AAAA, 0);
        // Timeout abort, then completion on the last allowed cycle.
        run_txn(32'h1A10_0020, 1'b0, 32'h0000_0000, 100, 1'b0, 32'h0BAD_0BAD, 0);
        run_txn(32'h1A10_0024, 1'b0, 32'h0000_0000, TO - 1, 1'b0, 32'h600D_600D, 0);
        // Response backpressure.
        run_txn(32'h1A10_0028, 1'b0, 32'h0000_0000, 1, 1'b0, 32'hA5A5_5A5A, 5);

        // Reset in the middle of a waited read drops the transfer.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h1A10_0030;
        req_we    = 1'b0;
        pready    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_penable", penable, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_penable", penable, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_paddr", paddr, 0);
        begin
            bit seen_rsp = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (rsp_valid) seen_rsp = 1'b1;
            end
            chk("mid_rst_no_rsp", seen_rsp, 0);
        end
        run_txn(32'h1A10_0034, 1'b0, 32'h0000_0000, 2, 1'b0, 32'h1357_9BDF, 1);

        // Randomized traffic.
        for (int t = 0; t < 25; t++) begin
            logic [AW-1:0] a = $urandom;
            int            sel = $urandom_range(0, 9);
            int            w;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            if (sel < 6)       w = $urandom_range(0, 3);
            else if (sel < 8)  w = $urandom_range(4, 14);
            else if (sel == 8) w = TO - 1;
            else               w = $urandom_range(TO, TO + 4);
            run_txn(a, 1'($urandom), $urandom, w, 1'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
